// File: rtl/matrix_stream_ctrl.sv
// Stream front/back end for an external 3x3 matrix multiplier: assembles two operand
// matrices from an element stream, waits out the multiplier latency, then streams the product.
module matrix_stream_ctrl #(
  parameter int unsigned MULT_LATENCY = 2,
  parameter int unsigned ELEM_W       = 3,
  parameter int unsigned RES_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [ELEM_W-1:0]    in_data,
  output logic                 in_ready,
  output logic [9*ELEM_W-1:0]  mm_inp1,
  output logic [9*ELEM_W-1:0]  mm_inp2,
  input  logic [9*RES_W-1:0]   mm_outp,
  output logic                 out_valid,
  output logic [RES_W-1:0]     out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int unsigned MatW  = 9 * ELEM_W;
  localparam int unsigned ResW  = 9 * RES_W;
  localparam int unsigned WaitW = (MULT_LATENCY > 0) ? $clog2(MULT_LATENCY + 1) : 1;

  typedef enum logic [1:0] {StLoad, StWait, StDrain} state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [3:0]         res_cnt_q, res_cnt_d;
  logic [MatW-1:0]    inp1_q, inp1_d, inp2_q, inp2_d;
  logic [ResW-1:0]    result_q, result_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StLoad;
      cnt_q     <= '0;
      wait_q    <= '0;
      res_cnt_q <= '0;
      inp1_q    <= '0;
      inp2_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      res_cnt_q <= res_cnt_d;
      inp1_q    <= inp1_d;
      inp2_q    <= inp2_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    res_cnt_d = res_cnt_q;
    inp1_d    = inp1_q;
    inp2_d    = inp2_q;
    result_d  = result_q;
    case (state_q)
      StLoad: begin
        // in_ready is only low in LOAD while rst is asserted, which also holds the registers
        if (in_valid) begin
          if (cnt_q < 5'd9) inp1_d[int'(cnt_q) * ELEM_W +: ELEM_W] = in_data;
          else              inp2_d[(int'(cnt_q) - 9) * ELEM_W +: ELEM_W] = in_data;
          if (cnt_q == 5'd17) begin
            cnt_d   = '0;
            wait_d  = WaitW'(MULT_LATENCY);
            state_d = StWait;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      StWait: begin
        if (wait_q == '0) begin
          result_d  = mm_outp;
          res_cnt_d = '0;
          state_d   = StDrain;
        end else begin
          wait_d = wait_q - WaitW'(1);
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (res_cnt_q == 4'd8) begin
            res_cnt_d = '0;
            state_d   = StLoad;
          end else begin
            res_cnt_d = res_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  assign in_ready  = (state_q == StLoad) && !rst;
  assign mm_inp1   = inp1_q;
  assign mm_inp2   = inp2_q;
  assign out_valid = (state_q == StDrain);
  assign out_last  = out_valid && (res_cnt_q == 4'd8);
  assign out_data  = out_valid ? result_q[int'(res_cnt_q) * RES_W +: RES_W] : '0;
  assign busy      = !((state_q == StLoad) && (cnt_q == 5'd0));

endmodule

// File: tb/tb_matrix_stream_ctrl.sv
// Randomised bench for matrix_stream_ctrl with a behavioural multiplier and matrix-product model.
module tb_matrix_stream_ctrl;

  localparam int unsigned ML = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_data;
  logic        in_ready;
  logic [26:0] mm_inp1, mm_inp2;
  logic [71:0] mm_outp;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  matrix_stream_ctrl #(.MULT_LATENCY(ML), .ELEM_W(3), .RES_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mm_inp1   (mm_inp1),
    .mm_inp2   (mm_inp2),
    .mm_outp   (mm_outp),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // C[i][j] = sum_k A[i][k] * B[k][j], row-major, 8-bit elements
  function automatic logic [71:0] matmul(input logic [26:0] a, input logic [26:0] b);
    logic [71:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < 3; k++) s += int'(a[(3*i+k)*3 +: 3]) * int'(b[(3*k+j)*3 +: 3]);
        r[(3*i+j)*8 +: 8] = s[7:0];
      end
    end
    return r;
  endfunction

  // External multiplier stand-in: ML register stages
  logic [71:0] pipe1, pipe2;
  always_ff @(posedge clk) begin
    pipe1 <= matmul(mm_inp1, mm_inp2);
    pipe2 <= pipe1;
  end
  assign mm_outp = pipe2;

  function automatic logic [26:0] pack9(input int v[9]);
    logic [26:0] m;
    for (int e = 0; e < 9; e++) m[e*3 +: 3] = v[e][2:0];
    return m;
  endfunction

  function automatic logic [26:0] rand_mat();
    logic [26:0] m;
    for (int e = 0; e < 9; e++) m[e*3 +: 3] = 3'($urandom_range(0, 7));
    return m;
  endfunction

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: in_valid held, 1: toggled 1010..., 2: random. Stops after n_acc accepts.
  task automatic load_pair(input logic [26:0] a, input logic [26:0] b, input int mode,
                           input int n_acc);
    int acc = 0;
    int cyc = 0;
    check_eq("load_in_ready", in_ready, 1);
    while (acc < n_acc && cyc < 200) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = (acc < 9) ? a[acc*3 +: 3] : b[(acc-9)*3 +: 3];
      if (in_valid && in_ready) acc++;
      cyc++;
      tick();
    end
    in_valid = 1'b0;
    in_data  = 3'($urandom_range(0, 7));
    check_eq("load_accepts", acc, n_acc);
    if (n_acc == 18) begin
      check_eq("in_ready_after_load", in_ready, 0);
      check_eq("busy_after_load", busy, 1);
      check_eq("mm_inp1", mm_inp1, a);
      check_eq("mm_inp2", mm_inp2, b);
    end
  endtask

  // mode 0: out_ready=1, 1: 3-cycle stall at element 4, 2: random. Stops after n_el handshakes.
  task automatic drain_check(input logic [26:0] a, input logic [26:0] b, input int mode,
                             input int n_el);
    logic [71:0] exp;
    int lat = 0;
    int k = 0;
    int stall = 0;
    int guard = 0;
    logic hs;
    exp = matmul(a, b);
    out_ready = 1'b1;
    while (!out_valid && lat < 50) begin
      check_eq("in_ready_wait", in_ready, 0);
      tick();
      lat++;
    end
    // WAIT spans ML+1 cycles, so out_valid first appears in the (ML+2)th cycle after the accept
    check_eq("latency", lat, ML + 1);
    while (k < n_el && guard < 300) begin
      guard++;
      case (mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = !(k == 4 && stall < 3);
          if (!out_ready) stall++;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      check_eq("out_valid", out_valid, 1);
      check_eq("out_data", out_data, exp[k*8 +: 8]);
      check_eq("out_last", out_last, (k == 8));
      hs = out_valid && out_ready;
      tick();
      if (hs) k++;
    end
    check_eq("drain_count", k, n_el);
    out_ready = 1'b1;
    if (n_el == 9) begin
      check_eq("out_valid_done", out_valid, 0);
      check_eq("in_ready_done", in_ready, 1);
      check_eq("busy_done", busy, 0);
      check_eq("mm_inp1_kept", mm_inp1, a);
      check_eq("mm_inp2_kept", mm_inp2, b);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_data"}, out_data, 0);
    check_eq({tag, "_out_last"}, out_last, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_mm_inp1"}, mm_inp1, 0);
    check_eq({tag, "_mm_inp2"}, mm_inp2, 0);
  endtask

  // Asynchronous assert between edges, release #1 after an edge
  task automatic apply_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state(tag);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq({tag, "_in_ready_release"}, in_ready, 1);
    check_eq({tag, "_busy_release"}, busy, 0);
  endtask

  logic [26:0] id_m, b1_m, sev_m, ra, rb;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    id_m  = pack9('{1, 0, 0, 0, 1, 0, 0, 0, 1});
    b1_m  = pack9('{1, 2, 3, 4, 5, 6, 7, 0, 1});
    sev_m = pack9('{7, 7, 7, 7, 7, 7, 7, 7, 7});
    #1;
    check_reset_state("por");
    tick();
    tick();
    rst = 1'b0;
    #1;

    load_pair(id_m, b1_m, 0, 18);
    drain_check(id_m, b1_m, 0, 9);

    load_pair(sev_m, sev_m, 0, 18);
    drain_check(sev_m, sev_m, 0, 9);

    load_pair(id_m, b1_m, 1, 18);
    drain_check(id_m, b1_m, 0, 9);

    load_pair(id_m, b1_m, 0, 18);
    drain_check(id_m, b1_m, 1, 9);

    // Partial load discarded by reset
    load_pair(rand_mat(), rand_mat(), 0, 10);
    check_eq("busy_partial", busy, 1);
    apply_reset("rst_load");
    load_pair(id_m, id_m, 0, 18);
    drain_check(id_m, id_m, 0, 9);

    // Drain aborted at element 5 by reset
    ra = rand_mat();
    rb = rand_mat();
    load_pair(ra, rb, 0, 18);
    drain_check(ra, rb, 0, 5);
    apply_reset("rst_drain");
    tick();
    check_eq("in_ready_after_rst", in_ready, 1);
    ra = rand_mat();
    rb = rand_mat();
    load_pair(ra, rb, 0, 18);
    drain_check(ra, rb, 0, 9);

    for (int r = 0; r < 6; r++) begin
      ra = rand_mat();
      rb = rand_mat();
      load_pair(ra, rb, 2, 18);
      drain_check(ra, rb, 2, 9);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
